// File: rtl/spectrum_bin_packer_if.sv
// Magnitude-stream input and bin-write output bundle of the spectrum bin packer.
// master drives the FFT magnitude stream; slave is the packer itself.
interface spectrum_bin_packer_if #(
    parameter int MAG_WIDTH = 16
);
    logic                 mag_valid;
    logic                 mag_sop;
    logic [MAG_WIDTH-1:0] mag_in;
    logic                 out_write;
    logic [7:0]           out_addr;
    logic [7:0]           out_data;
    logic                 frame_done;
    logic                 busy;

    modport master (
        output mag_valid, mag_sop, mag_in,
        input  out_write, out_addr, out_data, frame_done, busy
    );

    modport slave (
        input  mag_valid, mag_sop, mag_in,
        output out_write, out_addr, out_data, frame_done, busy
    );
endinterface

// File: rtl/spectrum_bin_packer.sv
// Groups consecutive FFT magnitudes into bands, takes each band's peak, scales and
// saturates it to 8 bits and issues a one-cycle write per band to the smoothing filter.
module spectrum_bin_packer #(
    parameter int NUM_BINS    = 40,
    parameter int BIN_WIDTH   = 4,
    parameter int START_INDEX = 1,
    parameter int MAG_WIDTH   = 16,
    parameter int SHIFT       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    spectrum_bin_packer_if.slave  bus
);
    localparam int BIN_W     = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam int SAMP_W    = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    // Skip counter holds 1..START_INDEX-1: the sample that reaches START_INDEX leaves SKIP.
    localparam int SKIP_W    = (START_INDEX > 2) ? $clog2(START_INDEX) : 1;
    localparam int SKIP_LAST = (START_INDEX > 0) ? START_INDEX - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_ACCUM
    } state_t;

    state_t               state_q, state_d;
    logic [SKIP_W-1:0]    skip_q, skip_d;
    logic [SAMP_W-1:0]    samp_q, samp_d;
    logic [BIN_W-1:0]     bin_q, bin_d;
    logic [MAG_WIDTH-1:0] peak_q, peak_d;
    logic                 write_q, write_d;
    logic [7:0]           addr_q, addr_d;
    logic [7:0]           data_q, data_d;
    logic                 done_q, done_d;

    logic                 restart;
    logic                 acc_en;
    logic [SAMP_W-1:0]    samp_cur;
    logic [BIN_W-1:0]     bin_cur;
    logic [MAG_WIDTH-1:0] peak_fin;

    function automatic logic [7:0] scale_sat(input logic [MAG_WIDTH-1:0] p);
        logic [MAG_WIDTH+7:0] ext;
        ext = {8'd0, p} >> SHIFT;
        return (ext > (MAG_WIDTH+8)'(255)) ? 8'hFF : ext[7:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            skip_q  <= '0;
            samp_q  <= '0;
            bin_q   <= '0;
            peak_q  <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            samp_q  <= samp_d;
            bin_q   <= bin_d;
            peak_q  <= peak_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        samp_d   = samp_q;
        bin_d    = bin_q;
        peak_d   = peak_q;
        write_d  = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = 1'b0;
        acc_en   = 1'b0;
        peak_fin = peak_q;

        // A sop from any state restarts the frame; the partial bin is simply dropped.
        restart  = bus.mag_valid & bus.mag_sop;
        samp_cur = restart ? '0 : samp_q;
        bin_cur  = restart ? '0 : bin_q;

        if (bus.mag_valid) begin
            if (bus.mag_sop) begin
                bin_d  = '0;
                samp_d = '0;
                skip_d = '0;
                if (START_INDEX == 0) begin
                    state_d = S_ACCUM;
                    acc_en  = 1'b1;
                end else if (START_INDEX == 1) begin
                    state_d = S_ACCUM;
                end else begin
                    state_d = S_SKIP;
                    skip_d  = SKIP_W'(1);
                end
            end else begin
                case (state_q)
                    S_SKIP: begin
                        if (skip_q == SKIP_W'(SKIP_LAST)) begin
                            state_d = S_ACCUM;
                            skip_d  = '0;
                        end else begin
                            skip_d = skip_q + SKIP_W'(1);
                        end
                    end
                    S_ACCUM: acc_en = 1'b1;
                    default: ;
                endcase
            end
        end

        if (acc_en) begin
            peak_fin = ((samp_cur == '0) || (bus.mag_in > peak_q)) ? bus.mag_in : peak_q;
            peak_d   = peak_fin;
            if (samp_cur == SAMP_W'(BIN_WIDTH - 1)) begin
                write_d = 1'b1;
                addr_d  = 8'(bin_cur);
                data_d  = scale_sat(peak_fin);
                samp_d  = '0;
                if (bin_cur == BIN_W'(NUM_BINS - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    bin_d   = '0;
                end else begin
                    bin_d = bin_cur + BIN_W'(1);
                end
            end else begin
                samp_d = samp_cur + SAMP_W'(1);
            end
        end
    end

    assign bus.out_write  = write_q;
    assign bus.out_addr   = addr_q;
    assign bus.out_data   = data_q;
    assign bus.frame_done = done_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_spectrum_bin_packer.sv
// Directed bench for spectrum_bin_packer: a default-parameter instance plus a
// BIN_WIDTH=1 / START_INDEX=0 instance, with writes captured by negedge monitors.
module tb_spectrum_bin_packer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spectrum_bin_packer_if #(.MAG_WIDTH(16)) ifa ();
    spectrum_bin_packer_if #(.MAG_WIDTH(16)) ifb ();

    spectrum_bin_packer #(
        .NUM_BINS(40), .BIN_WIDTH(4), .START_INDEX(1), .MAG_WIDTH(16), .SHIFT(4)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(ifa)
    );

    spectrum_bin_packer #(
        .NUM_BINS(40), .BIN_WIDTH(1), .START_INDEX(0), .MAG_WIDTH(16), .SHIFT(4)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(ifb)
    );

    typedef struct {
        int addr;
        int data;
        int done;
        int cyc;
    } wr_t;

    typedef struct {
        logic [15:0] mag;
        int          exp_data;
    } sat_vec_t;

    wr_t qa[$];
    wr_t qb[$];

    always @(negedge clk) begin
        if (ifa.out_write === 1'b1) begin
            qa.push_back('{int'(ifa.out_addr), int'(ifa.out_data), int'(ifa.frame_done), cyc});
            $display("[TB] A write addr=%0d data=%0d done=%0d cyc=%0d",
                     ifa.out_addr, ifa.out_data, ifa.frame_done, cyc);
        end
        if (ifb.out_write === 1'b1) begin
            qb.push_back('{int'(ifb.out_addr), int'(ifb.out_data), int'(ifb.frame_done), cyc});
            $display("[TB] B write addr=%0d data=%0d done=%0d cyc=%0d",
                     ifb.out_addr, ifb.out_data, ifb.frame_done, cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step_a(input logic v, input logic s, input logic [15:0] m, output int c);
        @(negedge clk);
        ifa.mag_valid = v;
        ifa.mag_sop   = s;
        ifa.mag_in    = m;
        c = cyc;
    endtask

    task automatic step_b(input logic v, input logic s, input logic [15:0] m, output int c);
        @(negedge clk);
        ifb.mag_valid = v;
        ifb.mag_sop   = s;
        ifb.mag_in    = m;
        c = cyc;
    endtask

    task automatic idle_a(input int n);
        int c;
        repeat (n) step_a(1'b0, 1'b0, 16'd0, c);
    endtask

    initial begin
        sat_vec_t sat_tbl[6];
        int       dc[162];
        int       c;
        int       c_last;
        int       cb0;

        sat_tbl[0] = '{16'hFFFF, 255};
        sat_tbl[1] = '{16'h0FF0, 255};
        sat_tbl[2] = '{16'h0070, 7};
        sat_tbl[3] = '{16'h1000, 255};
        sat_tbl[4] = '{16'h0010, 1};
        sat_tbl[5] = '{16'h0000, 0};

        ifa.mag_valid = 1'b0; ifa.mag_sop = 1'b0; ifa.mag_in = '0;
        ifb.mag_valid = 1'b0; ifb.mag_sop = 1'b0; ifb.mag_in = '0;

        // Power-on reset state
        repeat (3) @(negedge clk);
        check("rst_write",  ifa.out_write, 0);
        check("rst_addr",   ifa.out_addr, 0);
        check("rst_data",   ifa.out_data, 0);
        check("rst_done",   ifa.frame_done, 0);
        check("rst_busy",   ifa.busy, 0);
        check("rst_busy_b", ifb.busy, 0);
        rst = 1'b1;
        idle_a(2);

        // Nominal frame: mag = index*16, bin k peak = (4k+4)*16
        qa.delete();
        for (int i = 0; i < 162; i++) begin
            step_a(1'b1, i == 0, 16'(i * 16), c);
            dc[i] = c;
        end
        idle_a(3);
        check("nom_count", qa.size(), 40);
        for (int k = 0; k < qa.size() && k < 40; k++) begin
            check($sformatf("nom_addr[%0d]", k), qa[k].addr, k);
            check($sformatf("nom_data[%0d]", k), qa[k].data, 4 * k + 4);
            check($sformatf("nom_done[%0d]", k), qa[k].done, (k == 39) ? 1 : 0);
            check($sformatf("nom_cyc[%0d]", k),  qa[k].cyc, dc[4 * k + 4] + 1);
        end
        check("nom_busy_end", ifa.busy, 0);

        // Saturation table: full frames of a constant magnitude
        for (int r = 0; r < 6; r++) begin
            qa.delete();
            for (int i = 0; i < 161; i++) step_a(1'b1, i == 0, sat_tbl[r].mag, c);
            idle_a(3);
            check($sformatf("sat%0d_count", r), qa.size(), 40);
            for (int k = 0; k < qa.size(); k++)
                check($sformatf("sat%0d_data[%0d]", r, k), qa[k].data, sat_tbl[r].exp_data);
        end

        // Peak selection with valid gaps
        qa.delete();
        step_a(1'b1, 1'b1, 16'd0, c);
        foreach (sat_tbl[i]) begin end
        step_a(1'b1, 1'b0, 16'd100, c);  step_a(1'b0, 1'b0, 16'hFFFF, c);
        step_a(1'b1, 1'b0, 16'd3000, c); step_a(1'b0, 1'b0, 16'hFFFF, c); step_a(1'b0, 1'b0, 16'hFFFF, c);
        step_a(1'b1, 1'b0, 16'd50, c);   step_a(1'b0, 1'b0, 16'hFFFF, c);
        step_a(1'b1, 1'b0, 16'd200, c_last);
        idle_a(4);
        check("peak_count", qa.size(), 1);
        if (qa.size() > 0) begin
            check("peak_addr", qa[0].addr, 0);
            check("peak_data", qa[0].data, 187);
            check("peak_cyc",  qa[0].cyc, c_last + 1);
        end

        // sop on the bin-closing sample: no write for the aborted bin
        qa.delete();
        step_a(1'b1, 1'b1, 16'd0, c);
        for (int i = 1; i < 4; i++) step_a(1'b1, 1'b0, 16'(i * 16), c);
        step_a(1'b1, 1'b1, 16'h0500, c);
        for (int i = 0; i < 4; i++) step_a(1'b1, 1'b0, 16'h0200, c);
        idle_a(3);
        check("sopclose_count", qa.size(), 1);
        if (qa.size() > 0) begin
            check("sopclose_addr", qa[0].addr, 0);
            check("sopclose_data", qa[0].data, 32);
        end

        // Mid-frame sop two samples into bin 3
        qa.delete();
        step_a(1'b1, 1'b1, 16'd0, c);
        for (int i = 0; i < 14; i++) step_a(1'b1, 1'b0, 16'h0100, c);
        step_a(1'b1, 1'b1, 16'h7FFF, c);
        @(posedge clk); #1;
        check("midsop_busy_sop", ifa.busy, 1);
        for (int i = 0; i < 4; i++) begin
            step_a(1'b1, 1'b0, 16'h0300, c);
            @(posedge clk); #1;
            check($sformatf("midsop_busy[%0d]", i), ifa.busy, 1);
        end
        idle_a(2);
        check("midsop_count", qa.size(), 4);
        if (qa.size() == 4) begin
            check("midsop_addr2", qa[2].addr, 2);
            check("midsop_addr3", qa[3].addr, 0);
            check("midsop_data3", qa[3].data, 48);
        end

        // Asynchronous reset mid-frame (bin 5 accumulating)
        qa.delete();
        step_a(1'b1, 1'b1, 16'd0, c);
        for (int i = 0; i < 22; i++) step_a(1'b1, 1'b0, 16'h0340, c);
        @(posedge clk); #1;
        check("pre_rst_addr", ifa.out_addr, 4);
        check("pre_rst_busy", ifa.busy, 1);
        ifa.mag_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_write", ifa.out_write, 0);
        check("arst_addr",  ifa.out_addr, 0);
        check("arst_data",  ifa.out_data, 0);
        check("arst_done",  ifa.frame_done, 0);
        check("arst_busy",  ifa.busy, 0);
        @(negedge clk);
        rst = 1'b1;
        qa.delete();
        for (int i = 0; i < 10; i++) step_a(1'b1, 1'b0, 16'h0340, c);
        idle_a(3);
        check("postrst_count", qa.size(), 0);
        check("postrst_busy",  ifa.busy, 0);

        // BIN_WIDTH=1, START_INDEX=0: one write per cycle
        qb.delete();
        for (int k = 0; k < 41; k++) begin
            step_b(1'b1, k == 0, 16'(k * 16), c);
            if (k == 0) cb0 = c;
        end
        for (int k = 0; k < 3; k++) step_b(1'b0, 1'b0, 16'd0, c);
        check("bw1_count", qb.size(), 40);
        for (int k = 0; k < qb.size() && k < 40; k++) begin
            check($sformatf("bw1_addr[%0d]", k), qb[k].addr, k);
            check($sformatf("bw1_data[%0d]", k), qb[k].data, k);
            check($sformatf("bw1_cyc[%0d]", k),  qb[k].cyc, cb0 + 1 + k);
            check($sformatf("bw1_done[%0d]", k), qb[k].done, (k == 39) ? 1 : 0);
        end
        check("bw1_busy_end", ifb.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
